processor_host_port: RTL

PROCESSOR_HOST_PORT -- requirements
Module: processor_host_port

---
 rtl/processor_host_port_if.sv | 44 ++++
 rtl/processor_host_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/processor_host_port_if.sv
`default_nettype none
// ============================================================================
// Module      : processor_host_port_if
// Description : Bundles the processor read port, the table-memory port, the
//               distinguished-point output port and the host FIFO port.
//               slave  - seen by processor_host_port
//               master - seen by the processor / table / host side
// Ports       : rom_rqst/rom_addr/rom_data/rom_rdy     processor reads
//               tbl_rd_en/tbl_addr/tbl_rdata            table memory
//               outputing/result_0/result_1/output_ack  point output
//               dp_valid/dp_x/dp_y/dp_pop/dp_count      host FIFO view
// Revision    : 1.0 - initial release
// ============================================================================
interface processor_host_port_if #(
  parameter int R_BITS = 110
);
  logic              rom_rqst;
  logic [7:0]        rom_addr;
  logic [R_BITS-1:0] rom_data;
  logic              rom_rdy;
  logic              tbl_rd_en;
  logic [7:0]        tbl_addr;
  logic [R_BITS-1:0] tbl_rdata;
  logic              outputing;
  logic [R_BITS-1:0] result_0;
  logic [R_BITS-1:0] result_1;
  logic              output_ack;
  logic              dp_valid;
  logic [R_BITS-1:0] dp_x;
  logic [R_BITS-1:0] dp_y;
  logic              dp_pop;
  logic [15:0]       dp_count;

  modport slave (
    input  rom_rqst, rom_addr, tbl_rdata, outputing, result_0, result_1, dp_pop,
    output rom_data, rom_rdy, tbl_rd_en, tbl_addr, output_ack, dp_valid, dp_x, dp_y, dp_count
  );

  modport master (
    output rom_rqst, rom_addr, tbl_rdata, outputing, result_0, result_1, dp_pop,
    input  rom_data, rom_rdy, tbl_rd_en, tbl_addr, output_ack, dp_valid, dp_x, dp_y, dp_count
  );
endinterface
`default_nettype wire

// File: rtl/processor_host_port.sv
`default_nettype none
// ============================================================================
// Module      : processor_host_port
// Description : Host-side port of the point-search processor. Answers
//               processor table reads with a toggle handshake, and captures
//               distinguished points into a first-word-fall-through FIFO
//               that the host drains. Both paths run concurrently.
// Ports       : clk   - sole clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - processor_host_port_if.slave (all data/handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module processor_host_port #(
  parameter int R_BITS     = 110,
  parameter int TBL_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  processor_host_port_if.slave   bus
);

  localparam int              c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [2:0]      c_LAT   = 3'(TBL_LAT);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] c_RD_IDLE  = 3'd0;
  localparam logic [2:0] c_RD_ISSUE = 3'd1;
  localparam logic [2:0] c_RD_WAIT  = 3'd2;
  localparam logic [2:0] c_RD_ACK   = 3'd3;
  localparam logic [2:0] c_RD_DONE  = 3'd4;

  localparam logic [1:0] c_OUT_IDLE = 2'd0;
  localparam logic [1:0] c_OUT_CAPT = 2'd1;
  localparam logic [1:0] c_OUT_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // Read responder
  // --------------------------------------------------------------------------
  logic              r_rqst, r_rqst_d;
  logic [2:0]        r_rd_state, w_rd_next;
  logic [2:0]        r_wait_cnt;
  logic [7:0]        r_tbl_addr;
  logic [R_BITS-1:0] r_rom_data;
  logic              r_rom_rdy;
  logic              w_rqst_rise;
  logic              w_addr_load, w_tbl_rd_en, w_data_load, w_rdy_toggle;

  // Edge detect on the registered request; both stages reset to 0 so a
  // request held high through reset release looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rqst   <= 1'b0;
      r_rqst_d <= 1'b0;
    end else begin
      r_rqst   <= bus.rom_rqst;
      r_rqst_d <= r_rqst;
    end
  end

  assign w_rqst_rise = r_rqst & ~r_rqst_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= c_RD_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      c_RD_IDLE:  if (w_rqst_rise) w_rd_next = c_RD_ISSUE;
      c_RD_ISSUE: w_rd_next = c_RD_WAIT;
      c_RD_WAIT:  if (r_wait_cnt == 3'd1) w_rd_next = c_RD_ACK;
      c_RD_ACK:   w_rd_next = c_RD_DONE;
      c_RD_DONE:  if (!r_rqst) w_rd_next = c_RD_IDLE;
      default:    w_rd_next = c_RD_IDLE;
    endcase
  end

  always_comb begin
    w_addr_load  = 1'b0;
    w_tbl_rd_en  = 1'b0;
    w_data_load  = 1'b0;
    w_rdy_toggle = 1'b0;
    case (r_rd_state)
      c_RD_IDLE:  w_addr_load  = w_rqst_rise;
      c_RD_ISSUE: w_tbl_rd_en  = 1'b1;
      c_RD_WAIT:  w_data_load  = (r_wait_cnt == 3'd1);
      c_RD_ACK:   w_rdy_toggle = 1'b1;
      default:    ;
    endcase
  end

  // Counter runs TBL_LAT wait cycles; data is captured on the last one so
  // rom_data settles one cycle before rom_rdy flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl_addr <= 8'd0;
      r_wait_cnt <= 3'd0;
      r_rom_data <= '0;
      r_rom_rdy  <= 1'b0;
    end else begin
      if (w_addr_load)                   r_tbl_addr <= bus.rom_addr;
      if (w_tbl_rd_en)                   r_wait_cnt <= c_LAT;
      else if (r_rd_state == c_RD_WAIT)  r_wait_cnt <= r_wait_cnt - 3'd1;
      if (w_data_load)                   r_rom_data <= bus.tbl_rdata;
      if (w_rdy_toggle)                  r_rom_rdy  <= ~r_rom_rdy;
    end
  end

  assign bus.tbl_rd_en = w_tbl_rd_en;
  assign bus.tbl_addr  = r_tbl_addr;
  assign bus.rom_data  = r_rom_data;
  assign bus.rom_rdy   = r_rom_rdy;

  // --------------------------------------------------------------------------
  // Output capture
  // --------------------------------------------------------------------------
  logic              r_outp, r_outp_d;
  logic [1:0]        r_out_state, w_out_next;
  logic              r_ack;
  logic [15:0]       r_dp_count;
  logic              w_outp_rise, w_push, w_pop, w_full, w_empty;
  logic [R_BITS-1:0] r_mem_x [FIFO_DEPTH];
  logic [R_BITS-1:0] r_mem_y [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]   r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outp   <= 1'b0;
      r_outp_d <= 1'b0;
    end else begin
      r_outp   <= bus.outputing;
      r_outp_d <= r_outp;
    end
  end

  assign w_outp_rise = r_outp & ~r_outp_d;
  assign w_full      = (r_level == c_FULL);
  assign w_empty     = (r_level == '0);
  assign w_pop       = bus.dp_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_state <= c_OUT_IDLE;
    else        r_out_state <= w_out_next;
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      c_OUT_IDLE: if (w_outp_rise) w_out_next = c_OUT_CAPT;
      c_OUT_CAPT: if (!w_full)     w_out_next = c_OUT_DONE;
      c_OUT_DONE: if (!r_outp)     w_out_next = c_OUT_IDLE;
      default:    w_out_next = c_OUT_IDLE;
    endcase
  end

  // Full is judged on the level at cycle start, so a pop in the same cycle
  // as a full FIFO frees the slot for the following cycle's push.
  always_comb begin
    w_push = 1'b0;
    if (r_out_state == c_OUT_CAPT) w_push = ~w_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_dp_count <= 16'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      if (w_push) begin
        r_ack      <= ~r_ack;
        r_dp_count <= r_dp_count + 16'd1;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= bus.result_0;
      r_mem_y[r_wr_ptr] <= bus.result_1;
    end
  end

  assign bus.output_ack = r_ack;
  assign bus.dp_count   = r_dp_count;
  assign bus.dp_valid   = ~w_empty;
  assign bus.dp_x       = r_mem_x[r_rd_ptr];
  assign bus.dp_y       = r_mem_y[r_rd_ptr];

endmodule
`default_nettype wire
